readout_sequencer: RTL and testbench

Frame-level controller for the multi-channel impulse counter bank. Each rising edge of the RTC tick starts one readout frame. The sequencer first snapshots all channel counters. It then walks the enabled channels in ascending order, loads each snapshot word through the counter-bank read port, and shifts it out MSB-first on a single serial line. It sits between the counter bank and the chip's `serial_out` / address / `SL` pins, and flags RTC ticks that arrive while a frame is still in progress.

---
 rtl/readout_pkg.sv | 36 +++
 rtl/readout_sequencer_piso.sv | 36 +++
 rtl/readout_sequencer.sv | 127 ++++++++++++
 tb/tb_readout_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// Shared types and helpers for the readout sequencer: FSM state encoding,
// default sizing and the enabled-channel search.
package readout_pkg;

  localparam int RS_NCH = 8;
  localparam int RS_CW  = 16;
  localparam int RS_AW  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } rs_state_t;

  typedef struct packed {
    logic       none;
    logic [3:0] idx;
  } next_ch_t;

  // Lowest set bit of mask at or above index cur; none=1 when no such bit exists.
  function automatic next_ch_t next_en(input logic [15:0] mask, input logic [4:0] cur);
    next_ch_t r;
    r.none = 1'b1;
    r.idx  = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i] && (i >= int'(cur))) begin
        r.none = 1'b0;
        r.idx  = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/readout_sequencer_piso.sv
// Parallel-in/serial-out shift register with a bit down-counter; last marks
// the cycle in which the final bit of the word is at the MSB.
module piso_shifter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          shift,
  input  logic [CW-1:0] din,
  output logic          msb,
  output logic          last
);

  localparam int CNTW = $clog2(CW);

  logic [CW-1:0]   sr_q;
  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      sr_q  <= din;
      cnt_q <= CNTW'(CW - 1);
    end else if (shift) begin
      sr_q  <= {sr_q[CW-2:0], 1'b0};
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign msb  = sr_q[CW-1];
  assign last = (cnt_q == '0);

endmodule

// File: rtl/readout_sequencer.sv
// Frame controller: on each RTC rising edge snapshots the counter bank and
// streams every enabled channel's word MSB-first on serial_out.
import readout_pkg::*;

module readout_sequencer #(
  parameter int NCH = RS_NCH,
  parameter int CW  = RS_CW,
  parameter int AW  = RS_AW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rtc,
  input  logic [NCH-1:0] chan_en,
  input  logic [CW-1:0]  cnt_data,
  output logic           snap,
  output logic [AW-1:0]  addr,
  output logic           serial_out,
  output logic           sl_out,
  output logic           busy,
  output logic           frame_done,
  output logic           ovf_rtc_out
);

  rs_state_t      state, state_nxt;
  logic           rtc_q;
  logic           rtc_edge;
  logic [NCH-1:0] mask_q;
  logic [AW-1:0]  chan_q, chan_nxt;
  logic           ovf_q;
  logic           load, shift, msb, last;
  logic [15:0]    en_ext, mask_ext;
  next_ch_t       first_ch, following_ch;

  assign rtc_edge = rtc & ~rtc_q;

  // The first channel comes from the live mask (it is being latched this
  // cycle); later channels come from the frozen copy.
  always_comb begin
    en_ext            = '0;
    en_ext[NCH-1:0]   = chan_en;
    mask_ext          = '0;
    mask_ext[NCH-1:0] = mask_q;
    first_ch          = next_en(en_ext, 5'd0);
    following_ch      = next_en(mask_ext, 5'(chan_q) + 5'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      rtc_q  <= 1'b1;
      mask_q <= '0;
      chan_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      rtc_q  <= rtc;
      chan_q <= chan_nxt;
      if (state == ST_SNAP) mask_q <= chan_en;
      if (rtc_edge && (state != ST_IDLE)) ovf_q <= 1'b1;
      else if (state == ST_SNAP) ovf_q <= 1'b0;
    end
  end

  always_comb begin
    state_nxt  = state;
    chan_nxt   = chan_q;
    snap       = 1'b0;
    addr       = '0;
    serial_out = 1'b0;
    sl_out     = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (rtc_edge) state_nxt = ST_SNAP;
      end
      ST_SNAP: begin
        snap      = 1'b1;
        chan_nxt  = AW'(first_ch.idx);
        state_nxt = first_ch.none ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        addr      = chan_q;
        load      = 1'b1;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        addr       = chan_q;
        sl_out     = 1'b1;
        serial_out = msb;
        shift      = 1'b1;
        if (last) begin
          if (following_ch.none) begin
            state_nxt = ST_DONE;
          end else begin
            chan_nxt  = AW'(following_ch.idx);
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ovf_rtc_out = ovf_q;

  piso_shifter #(.CW(CW)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (cnt_data),
    .msb   (msb),
    .last  (last)
  );

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed self-checking bench for readout_sequencer with a behavioural
// counter bank returning 16'hA5C3 + channel.
module tb_readout_sequencer;

  logic        clk;
  logic        reset;
  logic        rtc;
  logic [7:0]  chan_en;
  logic [15:0] cnt_data;
  logic        snap;
  logic [3:0]  addr;
  logic        serial_out;
  logic        sl_out;
  logic        busy;
  logic        frame_done;
  logic        ovf_rtc_out;

  int checks = 0;
  int errors = 0;
  int cur_len = 0;
  int last_len = 0;

  readout_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .rtc         (rtc),
    .chan_en     (chan_en),
    .cnt_data    (cnt_data),
    .snap        (snap),
    .addr        (addr),
    .serial_out  (serial_out),
    .sl_out      (sl_out),
    .busy        (busy),
    .frame_done  (frame_done),
    .ovf_rtc_out (ovf_rtc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cnt_data = 16'hA5C3 + 16'(addr);

  // Length of the most recent busy window, in clock cycles.
  always @(posedge clk) begin
    if (busy) begin
      cur_len <= cur_len + 1;
    end else begin
      if (cur_len != 0) last_len <= cur_len;
      cur_len <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_snap"}, 32'(snap), 0);
    checkOutput({tag, "_addr"}, 32'(addr), 0);
    checkOutput({tag, "_ser"},  32'(serial_out), 0);
    checkOutput({tag, "_sl"},   32'(sl_out), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(frame_done), 0);
    checkOutput({tag, "_ovf"},  32'(ovf_rtc_out), 0);
  endtask

  // One frame cycle; cyc counts cycles after SNAP.
  task automatic step(inout int cyc, input logic [7:0] en_mid, input bit drops);
    tick();
    cyc++;
    if (cyc == 1) begin
      checkOutput("ovf_clear", 32'(ovf_rtc_out), 0);
      chan_en = en_mid;
    end
    if (drops) begin
      if (cyc == 10) rtc = 1'b0;
      if (cyc == 20) rtc = 1'b1;
      if (cyc == 30) rtc = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] en, input logic [7:0] en_mid, input bit drops,
                               input bit ovf_at_snap, input int exp_len);
    int cyc;
    logic [15:0] word;
    chan_en = en;
    rtc = 1'b0;
    tick();
    rtc = 1'b1;
    tick();
    checkOutput("snap_pulse", 32'(snap), 1);
    checkOutput("snap_busy", 32'(busy), 1);
    checkOutput("snap_sl", 32'(sl_out), 0);
    checkOutput("snap_ovf", 32'(ovf_rtc_out), 32'(ovf_at_snap));
    cyc = 0;
    for (int ch = 0; ch < 8; ch++) begin
      if (en[ch]) begin
        word = 16'hA5C3 + 16'(ch);
        step(cyc, en_mid, drops);
        checkOutput("load_addr", 32'(addr), 32'(ch));
        checkOutput("load_sl", 32'(sl_out), 0);
        checkOutput("load_ser", 32'(serial_out), 0);
        checkOutput("load_snap", 32'(snap), 0);
        for (int b = 15; b >= 0; b--) begin
          step(cyc, en_mid, drops);
          checkOutput("shift_sl", 32'(sl_out), 1);
          checkOutput("shift_addr", 32'(addr), 32'(ch));
          checkOutput("shift_bit", 32'(serial_out), 32'(word[b]));
        end
      end
    end
    step(cyc, en_mid, drops);
    checkOutput("done_pulse", 32'(frame_done), 1);
    checkOutput("done_busy", 32'(busy), 1);
    checkOutput("done_sl", 32'(sl_out), 0);
    if (drops) rtc = 1'b1;
    tick();
    checkOutput("idle_busy", 32'(busy), 0);
    checkOutput("idle_done", 32'(frame_done), 0);
    if (drops) checkOutput("ovf_set", 32'(ovf_rtc_out), 1);
    tick();
    tick();
    checkOutput("frame_len", 32'(last_len), 32'(exp_len));
  endtask

  initial begin
    reset = 1'b1;
    rtc = 1'b1;
    chan_en = 8'h00;
    tick();
    tick();
    checkIdleOutputs("reset");
    reset = 1'b0;
    repeat (4) tick();
    checkOutput("rtc_high_no_frame", 32'(busy), 0);

    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0, 138);
    applyStimulus(8'h85, 8'hFF, 1'b0, 1'b0, 53);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 2);
    applyStimulus(8'h0F, 8'h0F, 1'b1, 1'b0, 70);
    repeat (3) tick();
    checkOutput("ovf_sticky", 32'(ovf_rtc_out), 1);
    checkOutput("drop_no_frame", 32'(busy), 0);
    applyStimulus(8'h02, 8'h02, 1'b0, 1'b1, 19);

    // Abort a frame in the middle of channel 3's word.
    chan_en = 8'hFF;
    rtc = 1'b0;
    tick();
    rtc = 1'b1;
    tick();
    checkOutput("abort_snap", 32'(snap), 1);
    repeat (58) tick();
    checkOutput("abort_addr", 32'(addr), 3);
    checkOutput("abort_sl", 32'(sl_out), 1);
    reset = 1'b1;
    tick();
    checkIdleOutputs("abort");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("post_reset_busy", 32'(busy), 0);
      checkOutput("post_reset_done", 32'(frame_done), 0);
    end
    applyStimulus(8'h81, 8'h81, 1'b0, 1'b0, 36);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
